booth_mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `booth_multiplier` (32×32 signed, start/done handshake, 64-bit result) among `NUM_REQ` requesters. It accepts one operand pair at a time over a valid/ready handshake and drives the multiplier's `M`/`Q`/`start` inputs. It waits for a fresh `done`, then returns the 64-bit signed product to the granted requester over a valid/ready response channel. It sits between the ALU's issue logic and the shared multiplier.

---
 rtl/booth_mult_arbiter_pkg.sv | 13 +
 rtl/booth_mult_arbiter_rr_pick.sv | 24 ++
 rtl/booth_mult_arbiter.sv | 108 ++++++++++
 tb/tb_booth_mult_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_mult_arbiter_pkg.sv
// Shared widths and FSM encoding for the multiplier arbiter.
package booth_mult_arbiter_pkg;
    localparam int MUL_W  = 32;
    localparam int PROD_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_CLR,
        WAIT_DONE,
        RESP
    } state_e;
endpackage

// File: rtl/booth_mult_arbiter_rr_pick.sv
// Rotate-priority encoder: first set bit of req searching upward from ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      gnt_idx,
    output logic               any
);
    int idx;

    // Scan from the farthest offset down so the nearest-to-ptr requester wins last.
    always_comb begin
        gnt_idx = '0;
        idx     = 0;
        any     = |req;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[IW'(idx)]) gnt_idx = IW'(idx);
        end
    end
endmodule

// File: rtl/booth_mult_arbiter.sv
// Round-robin sequencer sharing one start/done multiplier among NUM_REQ requesters.
module booth_mult_arbiter
    import booth_mult_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*MUL_W-1:0] req_a,
    input  logic [NUM_REQ*MUL_W-1:0] req_b,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [PROD_W-1:0]        resp_result,
    output logic                     busy,
    output logic [MUL_W-1:0]         mul_M,
    output logic [MUL_W-1:0]         mul_Q,
    output logic                     mul_start,
    input  logic [PROD_W-1:0]        mul_result,
    input  logic                     mul_done
);
    localparam int IW = $clog2(NUM_REQ);

    state_e            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [MUL_W-1:0]  mul_m_q, mul_m_d;
    logic [MUL_W-1:0]  mul_q_q, mul_q_d;
    logic [PROD_W-1:0] res_q, res_d;
    logic [IW-1:0]     gnt_idx;
    logic              any;

    rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        mul_m_d    = mul_m_q;
        mul_q_d    = mul_q_q;
        res_d      = res_q;
        req_ready  = '0;
        resp_valid = '0;
        mul_start  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any) begin
                    req_ready[gnt_idx] = 1'b1;
                    mul_m_d = req_a[int'(gnt_idx)*MUL_W +: MUL_W];
                    mul_q_d = req_b[int'(gnt_idx)*MUL_W +: MUL_W];
                    owner_d = gnt_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mul_start = 1'b1;
                state_d   = WAIT_CLR;
            end
            // A done level left over from the previous product must drop first.
            WAIT_CLR: begin
                if (!mul_done) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (mul_done) begin
                    res_d   = mul_result;
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid[owner_q] = 1'b1;
                if (resp_ready[owner_q]) begin
                    ptr_d   = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            mul_m_q <= '0;
            mul_q_q <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            mul_m_q <= mul_m_d;
            mul_q_q <= mul_q_d;
            res_q   <= res_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign mul_M       = mul_m_q;
    assign mul_Q       = mul_q_q;
    assign resp_result = res_q;
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Randomized scoreboard bench for booth_mult_arbiter with a variable-latency multiplier model.
module tb_booth_mult_arbiter;
    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_ready;
    logic [NR*32-1:0] req_a = '0;
    logic [NR*32-1:0] req_b = '0;
    logic [NR-1:0]   resp_valid;
    logic [NR-1:0]   resp_ready = '0;
    logic [63:0]     resp_result;
    logic            busy;
    logic [31:0]     mul_M, mul_Q;
    logic            mul_start;
    logic [63:0]     mul_result = '0;
    logic            mul_done = 1'b0;

    booth_mult_arbiter #(.NUM_REQ(NR)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .busy(busy),
        .mul_M(mul_M), .mul_Q(mul_Q), .mul_start(mul_start),
        .mul_result(mul_result), .mul_done(mul_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Multiplier model: a stale done may linger for stale_cfg cycles after start,
    // then done is low for lat_cfg cycles before the fresh product appears.
    int lat_cfg = 3;
    int stale_cfg = 0;
    int hold_c = 0;
    int lat_c = 0;
    bit pend_m = 1'b0;
    logic [63:0] pprod = '0;

    always @(posedge clk) begin
        if (mul_start) begin
            pprod  <= 64'($signed(mul_M)) * 64'($signed(mul_Q));
            hold_c <= stale_cfg;
            lat_c  <= lat_cfg;
            pend_m <= 1'b1;
        end else if (hold_c > 0) begin
            hold_c <= hold_c - 1;
        end else if (lat_c > 0) begin
            mul_done <= 1'b0;
            lat_c    <= lat_c - 1;
        end else if (pend_m) begin
            mul_done   <= 1'b1;
            mul_result <= pprod;
            pend_m     <= 1'b0;
        end
    end

    // Reference model and monitor.
    typedef struct {
        int          owner;
        logic [63:0] prod;
    } exp_t;

    exp_t        exp_q[$];
    int          srv_owner[$];
    logic [63:0] srv_res[$];
    int  ptr_m = 0;
    bit  outstanding = 1'b0;
    bit  start_exp = 1'b0;
    bit  rst_prev = 1'b0;
    logic [31:0] a_m = '0, b_m = '0;

    always @(negedge clk) begin
        logic [NR-1:0] exp_rdy;
        logic signed [63:0] sa, sb;
        int gi;
        exp_t e;
        if (rst) begin
            exp_q.delete();
            ptr_m = 0;
            outstanding = 1'b0;
            start_exp = 1'b0;
            rst_prev = 1'b1;
        end else begin
            if (rst_prev) begin
                chk(resp_valid == '0, "rst_resp_valid", 64'(resp_valid), 64'd0);
                chk(resp_result == '0, "rst_resp_result", resp_result, 64'd0);
                chk(busy == 1'b0, "rst_busy", 64'(busy), 64'd0);
                chk(mul_M == '0 && mul_Q == '0, "rst_mul_ops", {mul_M, mul_Q}, 64'd0);
            end
            rst_prev = 1'b0;
            chk(busy == outstanding, "busy", 64'(busy), 64'(outstanding));
            chk(mul_start == start_exp, "mul_start", 64'(mul_start), 64'(start_exp));
            if (start_exp)
                chk(mul_M == a_m && mul_Q == b_m, "mul_operands", {mul_M, mul_Q}, {a_m, b_m});
            start_exp = 1'b0;
            exp_rdy = '0;
            gi = -1;
            if (!outstanding) begin
                for (int k = 0; k < NR; k++)
                    if (gi < 0 && req_valid[(ptr_m + k) % NR]) gi = (ptr_m + k) % NR;
            end
            if (gi >= 0) exp_rdy[gi] = 1'b1;
            chk(req_ready == exp_rdy, "req_ready", 64'(req_ready), 64'(exp_rdy));
            if (gi >= 0) begin
                a_m = req_a[gi*32 +: 32];
                b_m = req_b[gi*32 +: 32];
                sa = $signed(a_m);
                sb = $signed(b_m);
                e.owner = gi;
                e.prod = sa * sb;
                exp_q.push_back(e);
                outstanding = 1'b1;
                start_exp = 1'b1;
            end
            if (resp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "resp_unexpected", 64'(resp_valid), 64'd0);
                end else begin
                    e = exp_q[0];
                    chk(resp_valid == NR'(1 << e.owner), "resp_valid", 64'(resp_valid), 64'(1 << e.owner));
                    chk(resp_result == e.prod, "resp_result", resp_result, e.prod);
                    if (resp_ready[e.owner]) begin
                        srv_owner.push_back(e.owner);
                        srv_res.push_back(resp_result);
                        void'(exp_q.pop_front());
                        ptr_m = (e.owner + 1) % NR;
                        outstanding = 1'b0;
                    end
                end
            end
        end
    end

    // Stimulus: per-requester operand FIFOs, advanced one clock at a time.
    logic [63:0] pbuf [NR][256];
    int ph[NR];
    int pt[NR];
    int rdy_mode = 0;
    int hold_n = 0;

    task automatic push(input int r, input logic [31:0] a, input logic [31:0] b);
        pbuf[r][pt[r]] = {a, b};
        pt[r]++;
    endtask

    function automatic int pending_total();
        int s = 0;
        for (int i = 0; i < NR; i++) s += pt[i] - ph[i];
        return s;
    endfunction

    task automatic cyc();
        logic [NR-1:0] hs;
        logic [NR-1:0] rv;
        @(negedge clk);
        hs = rst ? '0 : (req_valid & req_ready);
        rv = resp_valid;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) if (hs[i]) ph[i]++;
        case (rdy_mode)
            0: resp_ready = '1;
            1: resp_ready = NR'($urandom);
            default: begin
                if (rv != '0) hold_n++;
                else if (hold_n >= 5) hold_n = 0;
                resp_ready = (hold_n >= 5) ? '1 : '0;
            end
        endcase
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = (pt[i] > ph[i]);
            req_a[i*32 +: 32] = (pt[i] > ph[i]) ? pbuf[i][ph[i]][63:32] : 32'h0;
            req_b[i*32 +: 32] = (pt[i] > ph[i]) ? pbuf[i][ph[i]][31:0] : 32'h0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((pending_total() > 0 || outstanding || exp_q.size() > 0) && t < 3000) begin
            cyc();
            t++;
        end
        chk(t < 3000, "drain_timeout", 64'(t), 64'd3000);
        cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] tbl [5];
        tbl[0] = 32'h0; tbl[1] = 32'h1; tbl[2] = 32'hFFFF_FFFF;
        tbl[3] = 32'h8000_0000; tbl[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 4) == 0) return tbl[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        int b;
        for (int i = 0; i < NR; i++) begin ph[i] = 0; pt[i] = 0; end
        do_reset();

        // Lone requester 1; then ptr should sit at 2.
        push(1, 32'd12345, 32'd6789);
        drain();
        b = srv_owner.size();
        chk(b >= 1 && srv_res[b-1] == 64'd83810205, "t1_result", (b >= 1) ? srv_res[b-1] : 64'h0, 64'd83810205);
        push(0, 32'd5, 32'd7);
        push(2, 32'd11, 32'd13);
        drain();
        chk(srv_owner.size() == b + 2 && srv_owner[b] == 2, "t1_ptr_after",
            64'(srv_owner[srv_owner.size()-2]), 64'd2);

        // Requesters 0 and 3 together from reset.
        do_reset();
        b = srv_owner.size();
        push(0, -32'sd12345, 32'd6789);
        push(3, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        drain();
        chk(srv_owner.size() == b + 2 && srv_owner[b] == 0 && srv_owner[b+1] == 3, "t2_order",
            64'(srv_owner[srv_owner.size()-1]), 64'd3);
        chk(srv_res[b] == -64'sd83810205, "t2_res0", srv_res[b], -64'sd83810205);
        chk(srv_res[b+1] == -64'sd2147483647, "t2_res3", srv_res[b+1], -64'sd2147483647);

        // All four requesting continuously.
        do_reset();
        b = srv_owner.size();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NR; i++) push(i, rand_op(), rand_op());
        drain();
        for (int j = 0; j < 8; j++)
            chk(srv_owner.size() > b + j && srv_owner[b+j] == j % NR, "t3_order",
                64'(srv_owner.size() > b + j ? srv_owner[b+j] : -1), 64'(j % NR));

        // Stale done from the previous op, long latency.
        lat_cfg = 34;
        stale_cfg = 3;
        b = srv_owner.size();
        push(2, 32'h8000_0000, 32'h8000_0000);
        drain();
        chk(srv_owner.size() > b && srv_res[b] == 64'd4611686018427387904, "t4_result",
            srv_res[srv_owner.size()-1], 64'd4611686018427387904);
        stale_cfg = 0;
        lat_cfg = 3;

        // Response back-pressure with another requester waiting.
        rdy_mode = 2;
        hold_n = 0;
        push(1, 32'd1000, -32'sd3);
        push(3, 32'd77, 32'd88);
        drain();
        rdy_mode = 0;

        // Reset while waiting for done; the late done must be ignored.
        lat_cfg = 20;
        push(0, 32'd1000, 32'd3);
        repeat (6) cyc();
        chk(busy == 1'b1, "t6_busy_before_rst", 64'(busy), 64'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        repeat (30) cyc();
        lat_cfg = 2;
        b = srv_owner.size();
        push(0, 32'd9, 32'd9);
        drain();
        chk(srv_owner.size() == b + 1 && srv_res[b] == 64'd81, "t6_recover",
            srv_res[srv_owner.size()-1], 64'd81);

        // Random traffic with random latencies and back-pressure.
        rdy_mode = 1;
        for (int n = 0; n < 400; n++) begin
            lat_cfg = $urandom_range(1, 6);
            stale_cfg = $urandom_range(0, 3);
            if (n < 300 && $urandom_range(0, 3) == 0) push($urandom_range(0, NR - 1), rand_op(), rand_op());
            cyc();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
